// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, latency lookup.
package alu_sequencer_pkg;

  localparam int NUM_OPS = 13;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Latency parameters below 1 behave as 1.
  function automatic int clamp_lat(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

  // Opcodes 13..15 have no ALU function.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_INC);
  endfunction

  // Cycles the ALU needs for an opcode; illegal opcodes report 1.
  function automatic int op_latency(input logic [3:0] op, input int mul_lat,
                                    input int div_lat, input int shift_lat);
    int lat;
    case (op)
      OP_MUL:                         lat = clamp_lat(mul_lat);
      OP_DIV:                         lat = clamp_lat(div_lat);
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: lat = clamp_lat(shift_lat);
      default:                        lat = 1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_sequencer_counter.sv
// Loadable down-counter with zero flag that times the EXEC phase.
module alu_seq_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; the counter never wraps because
  // the sequencer only decrements while nonzero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer that hands one operation at a time to a multi-cycle ALU and
// captures its 64-bit result.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int MUL_LAT   = 33,
  parameter int DIV_LAT   = 33,
  parameter int SHIFT_LAT = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           op,
  input  logic [31:0]          a_in,
  input  logic [31:0]          b_in,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [NUM_OPS-1:0]   alu_sel,
  output logic                 alu_start,
  input  logic [63:0]          alu_c,
  output logic [31:0]          z_hi,
  output logic [31:0]          z_lo,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam int L_MUL   = clamp_lat(MUL_LAT);
  localparam int L_DIV   = clamp_lat(DIV_LAT);
  localparam int L_SHIFT = clamp_lat(SHIFT_LAT);
  localparam int L_MD    = (L_MUL > L_DIV) ? L_MUL : L_DIV;
  localparam int MAX_LAT = (L_MD > L_SHIFT) ? L_MD : L_SHIFT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_op;
  logic               r_illegal;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [31:0]        r_z_hi;
  logic [31:0]        r_z_lo;
  logic               r_start;
  logic               w_accept;
  logic               w_op_legal;
  logic [CNT_W-1:0]   w_lat_m1;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_zero;
  logic               w_dec;
  logic               w_last;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_op_legal = op_legal(op);
  assign w_lat_m1   = CNT_W'(op_latency(op, MUL_LAT, DIV_LAT, SHIFT_LAT) - 1);
  assign w_dec      = (r_state == ST_EXEC) && !w_zero;
  assign w_last     = (r_state == ST_EXEC) && w_zero;

  alu_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (w_lat_m1),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    alu_sel   = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          w_next = w_op_legal ? ST_EXEC : ST_FIN;
        end
      end
      ST_EXEC: begin
        alu_sel = NUM_OPS'(1) << r_op;
        if (w_zero) begin
          w_next = ST_FIN;
        end
      end
      ST_FIN: begin
        done   = 1'b1;
        err    = r_illegal;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand and opcode capture on accept; held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_a   <= a_in;
      r_alu_b   <= b_in;
      r_op      <= op;
      r_illegal <= !w_op_legal;
    end
  end

  // Start pulse lands in the first EXEC cycle, only for legal opcodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start <= 1'b0;
    end else begin
      r_start <= w_accept && w_op_legal;
    end
  end

  // Result capture on the edge that ends the last EXEC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_z_hi <= '0;
      r_z_lo <= '0;
    end else if (w_last) begin
      r_z_hi <= alu_c[63:32];
      r_z_lo <= alu_c[31:0];
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_start = r_start;
  assign z_hi      = r_z_hi;
  assign z_lo      = r_z_lo;

  // Counter value is only observed through its zero flag.
  logic w_cnt_unused;
  assign w_cnt_unused = ^w_cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a latency-aware ALU model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   op = 4'd0;
  logic [31:0]  a_in = 32'd0;
  logic [31:0]  b_in = 32'd0;
  logic [31:0]  alu_a, alu_b;
  logic [12:0]  alu_sel;
  logic         alu_start;
  logic [63:0]  alu_c;
  logic [31:0]  z_hi, z_lo;
  logic         done, err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_start (alu_start),
    .alu_c     (alu_c),
    .z_hi      (z_hi),
    .z_lo      (z_lo),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  function automatic logic [63:0] calc(input logic [3:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] r;
    r = 64'h0;
    case (o)
      OP_ADD: r = {32'h0, a} + {32'h0, b};
      OP_SUB: r = {32'h0, a - b};
      OP_MUL: r = 64'(longint'($signed(a)) * longint'($signed(b)));
      OP_DIV: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_SHR: r = {32'hC0DE_0004, a >> b[4:0]};
      OP_SHL: r = {32'hC0DE_0005, a << b[4:0]};
      OP_ROR: r = {32'hC0DE_0006, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
      OP_ROL: r = {32'hC0DE_0007, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
      OP_AND: r = {32'hA5A5_A508, a & b};
      OP_OR:  r = {32'hA5A5_A509, a | b};
      OP_NEG: r = {32'hA5A5_A50A, -a};
      OP_NOT: r = {32'hA5A5_A50B, ~a};
      OP_INC: r = {32'hA5A5_A50C, a + 32'd1};
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] o);
    if (o == OP_MUL || o == OP_DIV || (o >= OP_SHR && o <= OP_ROL)) return 33;
    return 1;
  endfunction

  // ALU model: result only becomes valid once its latency has elapsed.
  logic [7:0] m_cnt;
  logic [7:0] m_cur;
  logic [3:0] m_op;
  always_comb begin
    m_cur = alu_start ? 8'd1 : m_cnt;
    m_op  = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (alu_sel[i]) m_op = 4'(i);
    end
    if (alu_sel != 13'd0 && int'(m_cur) >= lat_of(m_op)) alu_c = calc(m_op, alu_a, alu_b);
    else alu_c = 64'hBAD0_BAD0_BAD0_BAD0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) m_cnt <= 8'd0;
    else if (m_cur != 8'd0 && alu_sel != 13'd0 && m_cur != 8'd255) m_cnt <= m_cur + 8'd1;
    else m_cnt <= 8'd0;
  end

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit wait_neg);
    exp_t e;
    logic [63:0] r;
    if (wait_neg) @(negedge clk);
    req_valid = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    if (op_legal(o)) begin
      r = calc(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.err = 1'b0;
      last_hi = e.hi;
      last_lo = e.lo;
    end else begin
      e.hi = last_hi;
      e.lo = last_lo;
      e.err = 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic watch(input int maxc, input logic [12:0] sel_exp, output int k_done,
                       output int starts, output int ready_hi, output int sel_on,
                       output int sel_bad);
    k_done = -1; starts = 0; ready_hi = 0; sel_on = 0; sel_bad = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (alu_start === 1'b1) starts++;
      if (req_ready === 1'b1) ready_hi++;
      if (alu_sel !== 13'd0) begin
        sel_on++;
        if (alu_sel !== sel_exp) sel_bad++;
      end
      if (done === 1'b1) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({alu_a, alu_b, z_hi, z_lo} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {alu_a, alu_b, z_hi, z_lo});
    end
    n_tests++;
    if ({alu_sel, alu_start, done, err, busy, req_ready} !== 18'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required %b", {alu_sel, alu_start, done, err, busy, req_ready}, 18'b1);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b);
    int k, s, rh, on, sb, lat;
    exp_t e;
    lat = op_legal(o) ? lat_of(o) : 0;
    send(o, a, b, 1'b1);
    watch(lat + 10, op_legal(o) ? (13'd1 << o) : 13'd0, k, s, rh, on, sb);
    n_tests++;
    if (k !== lat + 1) begin
      n_fail++;
      $display("FAIL %s_latency: done at cycle %0d required %0d", name, k, lat + 1);
    end
    n_tests++;
    if (s !== (op_legal(o) ? 1 : 0) || on !== lat || sb !== 0) begin
      n_fail++;
      $display("FAIL %s_start_sel: starts %0d sel_cycles %0d sel_bad %0d required %0d %0d 0",
               name, s, on, sb, op_legal(o) ? 1 : 0, lat);
    end
    n_tests++;
    if (rh !== 0) begin
      n_fail++;
      $display("FAIL %s_ready_busy: ready high %0d cycles required 0", name, rh);
    end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: queue empty required 1 entry", name);
    end else begin
      e = exp_q.pop_front();
      if (z_hi !== e.hi || z_lo !== e.lo || err !== e.err) begin
        n_fail++;
        $display("FAIL %s_result: z=%h_%h err=%b required %h_%h err=%b",
                 name, z_hi, z_lo, err, e.hi, e.lo, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dcount;
    int k, s, rh, on, sb;
    exp_t e;
    send(OP_DIV, 32'd100, 32'd7, 1'b1);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({alu_a, alu_b, z_hi, z_lo, alu_sel, alu_start, done, err, busy, req_ready} !== 146'd1) begin
      n_fail++;
      $display("FAIL midreset_async: a=%h b=%h z=%h_%h sel=%h st=%b d=%b e=%b bsy=%b rdy=%b required zeros with ready 1",
               alu_a, alu_b, z_hi, z_lo, alu_sel, alu_start, done, err, busy, req_ready);
    end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
      if (i == 2) reset = 1'b1;
    end
    n_tests++;
    if (dcount !== 0 || z_hi !== 32'd0 || z_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_abandon: done pulses %0d z=%h_%h required 0 and 0", dcount, z_hi, z_lo);
    end
    exp_q.delete();
    last_hi = 32'd0;
    last_lo = 32'd0;
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    send(OP_ADD, 32'd20, 32'd22, 1'b0);
    watch(6, 13'd1, k, s, rh, on, sb);
    n_tests++;
    if (k !== 2 || s !== 1) begin
      n_fail++;
      $display("FAIL postreset_add_timing: done cycle %0d starts %0d required 2 and 1", k, s);
    end
    n_tests++;
    e = exp_q.pop_front();
    if (z_lo !== e.lo || z_hi !== e.hi || err !== 1'b0) begin
      n_fail++;
      $display("FAIL postreset_add_result: z=%h_%h err=%b required %h_%h 0", z_hi, z_lo, err, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] start_mask, done_mask;
    int a_bad;
    exp_t e;
    start_mask = '0; done_mask = '0; a_bad = 0;
    @(negedge clk);
    req_valid = 1'b1; op = OP_ADD; a_in = 32'd1; b_in = 32'd2;
    e.hi = 32'd0; e.lo = 32'd3; e.err = 1'b0; exp_q.push_back(e);
    e.lo = 32'd300; exp_q.push_back(e);
    @(posedge clk);
    #1 a_in = 32'd100; b_in = 32'd200;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (alu_start === 1'b1) start_mask[c] = 1'b1;
      if (c <= 3 && alu_a !== 32'd1) a_bad++;
      if (c >= 4 && alu_a !== 32'd100) a_bad++;
      if (done === 1'b1) begin
        done_mask[c] = 1'b1;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_scoreboard: queue empty at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          if (z_lo !== e.lo || z_hi !== e.hi || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: cycle %0d z=%h_%h required %h_%h", c, z_hi, z_lo, e.hi, e.lo);
          end
        end
      end
      if (c == 5) req_valid = 1'b0;
    end
    n_tests++;
    if (start_mask !== 9'h012) begin
      n_fail++;
      $display("FAIL b2b_start: start cycles %b required %b", start_mask, 9'h012);
    end
    n_tests++;
    if (done_mask !== 9'h024) begin
      n_fail++;
      $display("FAIL b2b_done: done cycles %b required %b", done_mask, 9'h024);
    end
    n_tests++;
    if (a_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_operand_hold: %0d bad alu_a cycles required 0", a_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single("add", OP_ADD, 32'd5, 32'd7);
    test_single("mul", OP_MUL, 32'hFFFF_FFFD, 32'd4);
    test_single("shl", OP_SHL, 32'd3, 32'd4);
    test_single("and_hi", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    test_single("illegal", 4'hE, 32'd9, 32'd9);
    test_single("inc", OP_INC, 32'hFFFF_FFFF, 32'd0);
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
